// File: rtl/gpio_pin_pkg.sv
// gpio_pin_pkg: shared GPIO pin types and idle levels.
// Used by gpio_pin_driver and the GPIO input filter.
package gpio_pin_pkg;

  typedef enum logic [1:0] {
    RELEASED = 2'd0,
    SETUP    = 2'd1,
    DRIVE    = 2'd2
  } state_t;

  localparam logic PIN_IDLE_LEVEL = 1'b1;
  localparam logic PIN_IDLE_OE    = 1'b0;

endpackage

// File: rtl/gpio_pin_driver.sv
// gpio_pin_driver: setup/min-hold GPIO output driver.
// Build macro GPIO_PIN_DRIVER_READBACK_EN adds drive-fight detection.
module gpio_pin_driver
  import gpio_pin_pkg::*;
#(
  parameter int SETUP_TICKS   = 1,
  parameter int MIN_HOLD      = 2,
  parameter int CONTEND_TICKS = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  logic ena,
  input  logic din,
  input  logic oe_req,
  input  logic pin_in,
  output logic pin_out,
  output logic pin_oe,
  output logic busy,
  output logic contention
);

  localparam int SW = (SETUP_TICKS > 0) ?
                      $clog2(SETUP_TICKS + 1) : 1;
  localparam int HW = $clog2(MIN_HOLD + 1);

  localparam logic [SW-1:0] SET_LD =
    SW'((SETUP_TICKS > 0) ? SETUP_TICKS - 1 : 0);
  localparam logic [HW-1:0] HOLD_LD = HW'(MIN_HOLD - 1);

  state_t          state;
  logic [SW-1:0]   set_cnt;
  logic [HW-1:0]   hold_cnt;
  logic            req;

`ifdef GPIO_PIN_DRIVER_READBACK_EN
  localparam int MW = $clog2(CONTEND_TICKS + 1);
  localparam logic [MW-1:0] MIS_TRIP =
    MW'(CONTEND_TICKS - 1);

  logic [MW-1:0] mis_cnt;
  logic          cont_q;

  // A tripped driver refuses new requests until software backs off.
  assign req        = oe_req & ~cont_q;
  assign contention = cont_q;
`else
  logic unused_pin_in;

  assign unused_pin_in = pin_in;
  assign req           = oe_req;
  assign contention    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= RELEASED;
      pin_out  <= PIN_IDLE_LEVEL;
      pin_oe   <= PIN_IDLE_OE;
      set_cnt  <= '0;
      hold_cnt <= '0;
`ifdef GPIO_PIN_DRIVER_READBACK_EN
      mis_cnt  <= '0;
      cont_q   <= 1'b0;
`endif
    end else if (ena) begin
      unique case (state)
        RELEASED: begin
          pin_out <= din;
`ifdef GPIO_PIN_DRIVER_READBACK_EN
          if (!oe_req) cont_q <= 1'b0;
`endif
          if (req) begin
            if (SETUP_TICKS == 0) begin
              pin_oe   <= 1'b1;
              hold_cnt <= HOLD_LD;
              state    <= DRIVE;
            end else begin
              set_cnt <= SET_LD;
              state   <= SETUP;
            end
          end
        end
        SETUP: begin
          if (!oe_req) begin
            state <= RELEASED;
          end else if (set_cnt == '0) begin
            pin_oe   <= 1'b1;
            hold_cnt <= HOLD_LD;
            state    <= DRIVE;
          end else begin
            set_cnt <= set_cnt - SW'(1);
          end
        end
        DRIVE: begin
          if (!oe_req) begin
            pin_oe <= 1'b0;
            state  <= RELEASED;
`ifdef GPIO_PIN_DRIVER_READBACK_EN
            mis_cnt <= '0;
`endif
          end else if (hold_cnt != '0) begin
            hold_cnt <= hold_cnt - HW'(1);
          end else if (din != pin_out) begin
            pin_out  <= din;
            hold_cnt <= HOLD_LD;
`ifdef GPIO_PIN_DRIVER_READBACK_EN
            mis_cnt  <= '0;
          end else if (pin_in == pin_out) begin
            mis_cnt <= '0;
          end else if (mis_cnt == MIS_TRIP) begin
            cont_q  <= 1'b1;
            pin_oe  <= 1'b0;
            mis_cnt <= '0;
            state   <= RELEASED;
          end else begin
            mis_cnt <= mis_cnt + MW'(1);
`endif
          end
        end
        default: begin
          pin_oe <= 1'b0;
          state  <= RELEASED;
        end
      endcase
    end
  end

  assign busy = (state == SETUP) |
                ((state == DRIVE) & (hold_cnt != '0));

endmodule

// File: tb/tb_gpio_pin_driver.sv
// tb_gpio_pin_driver: random + directed bench for gpio_pin_driver.
// Reference model tracks elapsed ticks per phase with plain ints.
module tb_gpio_pin_driver;

  localparam int S = 1;
  localparam int M = 2;
  localparam int C = 4;

`ifdef GPIO_PIN_DRIVER_READBACK_EN
  localparam bit RB = 1'b1;
`else
  localparam bit RB = 1'b0;
`endif

  logic clk;
  logic reset_n;
  logic ena;
  logic din;
  logic oe_req;
  logic pin_in;
  logic pin_out;
  logic pin_oe;
  logic busy;
  logic contention;

  int n_checks;
  int n_fail;

  bit m_out;
  bit m_setting;
  bit m_driving;
  bit m_cont;
  int m_age;
  int m_held;
  int m_mis;

  gpio_pin_driver #(
    .SETUP_TICKS  (S),
    .MIN_HOLD     (M),
    .CONTEND_TICKS(C)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .ena       (ena),
    .din       (din),
    .oe_req    (oe_req),
    .pin_in    (pin_in),
    .pin_out   (pin_out),
    .pin_oe    (pin_oe),
    .busy      (busy),
    .contention(contention)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_out     = 1'b1;
    m_setting = 1'b0;
    m_driving = 1'b0;
    m_cont    = 1'b0;
    m_age     = 0;
    m_held    = 0;
    m_mis     = 0;
  endtask

  // One ena tick of the pin rules, counting ticks upward.
  task automatic model_tick(input bit d, input bit r,
                            input bit pi);
    if (m_driving) begin
      if (!r) begin
        m_driving = 1'b0;
        m_mis     = 0;
      end else if (m_held + 1 < M) begin
        m_held++;
      end else if (d != m_out) begin
        m_out  = d;
        m_held = 0;
        m_mis  = 0;
      end else begin
        m_held = M;
        if (RB) begin
          if (pi != m_out) begin
            m_mis++;
            if (m_mis >= C) begin
              m_cont    = 1'b1;
              m_driving = 1'b0;
              m_mis     = 0;
            end
          end else begin
            m_mis = 0;
          end
        end
      end
    end else if (m_setting) begin
      if (!r) begin
        m_setting = 1'b0;
      end else if (m_age + 1 >= S) begin
        m_setting = 1'b0;
        m_driving = 1'b1;
        m_held    = 0;
      end else begin
        m_age++;
      end
    end else begin
      m_out = d;
      if (r && !m_cont) begin
        if (S == 0) begin
          m_driving = 1'b1;
          m_held    = 0;
        end else begin
          m_setting = 1'b1;
          m_age     = 0;
        end
      end
      if (RB && !r) m_cont = 1'b0;
    end
  endtask

  task automatic compare_all(input string tag);
    bit exp_busy;
    exp_busy = m_setting || (m_driving && (m_held < M - 1));
    check({tag, "_out"},  pin_out,    m_out);
    check({tag, "_oe"},   pin_oe,     m_driving);
    check({tag, "_busy"}, busy,       exp_busy);
    check({tag, "_cont"}, contention, m_cont);
  endtask

  task automatic cycle(input string tag, input bit e,
                       input bit d, input bit r,
                       input bit pi);
    ena    = e;
    din    = d;
    oe_req = r;
    pin_in = pi;
    @(posedge clk);
    if (e) model_tick(d, r, pi);
    #1;
    compare_all(tag);
  endtask

  task automatic async_reset(input string tag);
    reset_n = 1'b0;
    #1;
    check({tag, "_out"},  pin_out, 1'b1);
    check({tag, "_oe"},   pin_oe,  1'b0);
    check({tag, "_busy"}, busy,    1'b0);
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset_n  = 1'b1;
    ena      = 1'b1;
    din      = 1'b0;
    oe_req   = 1'b0;
    pin_in   = 1'b0;
    model_reset();
    #3 reset_n = 1'b0;
    #1;
    check("rst_out",  pin_out,    1'b1);
    check("rst_oe",   pin_oe,     1'b0);
    check("rst_busy", busy,       1'b0);
    check("rst_cont", contention, 1'b0);
    @(negedge clk);
    reset_n = 1'b1;

    cycle("t1", 1, 0, 0, 0);
    check("t1_low", pin_out, 1'b0);
    check("t1_off", pin_oe,  1'b0);

    cycle("t2a", 1, 0, 1, 0);
    check("t2_out0",  pin_out, 1'b0);
    check("t2_busy0", busy,    1'b1);
    check("t2_oe0",   pin_oe,  1'b0);
    cycle("t2b", 1, 1, 1, 1);
    check("t2_oe1",  pin_oe,  1'b1);
    check("t2_keep", pin_out, 1'b0);

    for (int i = 0; i < 10; i++)
      cycle("t3", 1, 1'(i), 1, 1'(i));
    for (int i = 0; i < 30; i++)
      cycle("t3e", (i % 3) == 0, 1'(i), 1, 1'(i));

    for (int i = 0; i < 6; i++)
      cycle("t4w", 1, 1, 1, 1);
    cycle("t4c", 1, 0, 1, 0);
    cycle("t4r", 1, 1, 0, 1);
    check("t4_oe",   pin_oe,  1'b0);
    check("t4_hold", pin_out, 1'b0);
    cycle("t4f", 1, 1, 0, 1);
    check("t4_fol", pin_out, 1'b1);

    cycle("t5a", 1, 0, 1, 0);
    async_reset("t5s");
    cycle("t5b", 1, 0, 1, 0);
    cycle("t5c", 1, 0, 1, 0);
    check("t5_drv", pin_oe, 1'b1);
    async_reset("t5d");

`ifdef GPIO_PIN_DRIVER_READBACK_EN
    cycle("t6i", 1, 0, 0, 0);
    for (int i = 0; i < 7; i++)
      cycle("t6", 1, 0, 1, 1);
    check("t6_trip", contention, 1'b1);
    check("t6_oe",   pin_oe,     1'b0);
    for (int i = 0; i < 3; i++)
      cycle("t6g", 1, 0, 1, 1);
    check("t6_ign", pin_oe, 1'b0);
    cycle("t6c", 1, 0, 0, 0);
    check("t6_clr", contention, 1'b0);
`endif

    for (int i = 0; i < 3000; i++) begin
      bit e, d, r, pi;
      e  = ($urandom % 4) != 0;
      d  = 1'($urandom);
      r  = ($urandom % 8) != 0;
      pi = (($urandom % 3) == 0) ? ~m_out : m_out;
      cycle("rnd", e, d, r, pi);
      if (($urandom % 500) == 0) async_reset("rrst");
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
